matvec_fxp_engine: RTL
======================

// Module: matvec_fxp_engine
// PURPOSE
// Runtime-sized, fixed-point matrix-vector multiplier with AXI-Stream operand and result ports.
// - Sits behind the DMA streams, in place of the fixed-size float interface.
// - Loads an N-element vector, then consumes an MxN matrix in row-major order.
// - Emits M dot-product results, with TLAST on the final row.
// PARAMETERS
// D_WIDTH    32                           operand/result width, signed two's complement
// FRAC_BITS  16                           fractional bits (Q format) of operands and result
// MAX_SIZE   16                           maximum rows and cols; sizes the vector store
// ACC_WIDTH  2*D_WIDTH+$clog2(MAX_SIZE)   accumulator width; never overflows internally
// PORTS
// aclk                 in   1          clock, rising edge
// aresetn              in   1          asynchronous active-low reset
// reset_done           out  1          high once the post-reset store clear completes
// cfg_rows             in   SW         matrix rows M, SW=$clog2(MAX_SIZE+1); sampled at job start
// cfg_cols             in   SW         matrix cols N = vector length; sampled at job start
// cfg_err              out  1          sticky; set by an illegal size, cleared only by reset
// busy                 out  1          high from job start until the last result is accepted
// s_axis_vector_valid  in   1          vector word valid
// s_axis_vector        in   D_WIDTH    vector element
// s_axis_vector_ready  out  1          vector word accepted when valid&ready
// s_axis_matrix_valid  in   1          matrix word valid
// s_axis_matrix        in   D_WIDTH    matrix element, row-major order
// s_axis_matrix_ready  out  1          matrix word accepted when valid&ready
// m_axis_result_valid  out  1          result valid
// m_axis_result        out  D_WIDTH    row dot product in Q(FRAC_BITS)
// m_axis_result_last   out  1          high with the result of row M-1
// m_axis_result_ready  in   1          downstream ready
// BEHAVIOUR
// - Reset (async assert, sync deassert):
//   - All outputs are 0; the FSM enters INIT.
//   - A reset mid-job abandons the job and drops any held result.
// - INIT: writes 0 to vector store entries 0..MAX_SIZE-1, one per cycle.
//   - reset_done rises the cycle after the last write; the FSM goes to IDLE.
// - IDLE:
//   - s_axis_vector_ready = 1 only if cfg_rows is in 1..MAX_SIZE, cfg_cols is in 1..MAX_SIZE and cfg_err=0.
//   - An illegal size with s_axis_vector_valid=1 sets cfg_err next cycle and keeps the FSM in IDLE.
//   - The first vector handshake latches M and N, stores vec[0], sets busy and moves to LOAD.
// - LOAD: one vector word per handshake into vec[col]; s_axis_matrix_ready=0.
//   - After word N-1: col=0, row=0, acc=0, move to MAC.
// - MAC: s_axis_matrix_ready = !m_axis_result_valid | m_axis_result_ready; throughput 1 word/cycle.
//   - Each handshake: acc += sext(matrix*vec[col]), using the full 2*D_WIDTH signed product.
//   - On col=N-1: load the result register and set m_axis_result_valid next cycle.
//     - Latency: 1 cycle from the last row handshake.
//     - m_axis_result_last = (row==M-1). acc=0, col=0, row++.
//   - After the handshake with row=M-1 and col=N-1: s_axis_matrix_ready=0, go to DRAIN.
// - DRAIN: hold the result until accepted; then clear busy and return to IDLE.
//   - A new job reloads the vector.
// - Output rules:
//   - result/last/valid are stable while valid=1 and ready=0.
//   - Accept-and-refill in the same cycle is legal, with no bubble.
// - Scaling: res = acc >>> FRAC_BITS (arithmetic shift; rounds toward -inf), then the low D_WIDTH bits (wraps).
// - cfg_* changes while busy=1 are ignored. Vector traffic outside IDLE/LOAD is not accepted.
// - Matrix traffic outside MAC is not accepted.
// CONFIGURATION
// - MATVEC_SATURATE_EN defined:
//   - The scaled result is clamped to [-2^(D_WIDTH-1), 2^(D_WIDTH-1)-1].
//   - Adds no latency.
// - MATVEC_SATURATE_EN undefined: the scaled result wraps to its low D_WIDTH bits.
// TESTING (D_WIDTH=32, FRAC_BITS=16, MAX_SIZE=16; 1.0=0x00010000)
// - Reset release -> reset_done=0 for 16 cycles then 1; all stream readies 0 during INIT.
// - M=N=2; vec={3,5}; mat={1,2,4,8} -> results 0x000D0000 (last=0) then 0x00340000 (last=1); busy falls after accept.
// - M=1,N=1; mat=-1.5 (0xFFFE8000), vec=2.0 -> 0xFFFD0000, last=1.
// - M=1,N=2; all four elements = 200.0 (0x00C80000):
//   - with MATVEC_SATURATE_EN -> 0x7FFFFFFF;
//   - without it -> 0x38800000.
// - M=N=4 with m_axis_result_ready held 0 for 5 cycles after the first result:
//   - s_axis_matrix_ready=0 while valid&!ready; no word lost; all 4 results match the golden model.
// - cfg_cols=0 with vector valid -> cfg_err=1, vector ready stays 0.
// - Assert aresetn mid-MAC -> outputs 0 and busy=0 immediately; INIT reruns.

Source files
------------

// File: rtl/matvec_fxp_engine.sv
// Runtime-sized Q-format matrix-vector multiplier with AXI-Stream vector/matrix inputs and result output.
// Optional build macro MATVEC_SATURATE_EN clamps the scaled result instead of wrapping it.
module matvec_fxp_engine #(
  parameter int D_WIDTH   = 32,
  parameter int FRAC_BITS = 16,
  parameter int MAX_SIZE  = 16,
  parameter int ACC_WIDTH = 2*D_WIDTH + $clog2(MAX_SIZE),
  parameter int SW        = $clog2(MAX_SIZE+1)
) (
  input  logic               aclk,
  input  logic               aresetn,
  output logic               reset_done,
  input  logic [SW-1:0]      cfg_rows,
  input  logic [SW-1:0]      cfg_cols,
  output logic               cfg_err,
  output logic               busy,
  input  logic               s_axis_vector_valid,
  input  logic [D_WIDTH-1:0] s_axis_vector,
  output logic               s_axis_vector_ready,
  input  logic               s_axis_matrix_valid,
  input  logic [D_WIDTH-1:0] s_axis_matrix,
  output logic               s_axis_matrix_ready,
  output logic               m_axis_result_valid,
  output logic [D_WIDTH-1:0] m_axis_result,
  output logic               m_axis_result_last,
  input  logic               m_axis_result_ready,
  output logic [2:0]         dbg_state
);
  // Handshakes: a word moves on a rising edge where valid & ready are both high; a held
  // result keeps data/last/valid stable until ready, and may be replaced in the accepting cycle.
  localparam int CW = $clog2(MAX_SIZE);

  typedef enum logic [2:0] {S_INIT = 3'd0, S_IDLE, S_LOAD, S_MAC, S_DRAIN} state_t;
  state_t r_state, w_next;

  logic [SW-1:0]            r_m, r_n, r_col, r_row;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic [D_WIDTH-1:0]       r_res;
  logic                     r_res_valid, r_res_last, r_busy, r_cfg_err, r_reset_done;
  logic [D_WIDTH-1:0]       r_vec [MAX_SIZE];

  logic                     w_size_ok, w_col_last, w_row_last;
  logic                     w_vec_ready, w_mat_ready, w_vec_hs, w_mat_hs;
  logic                     w_vec_we;
  logic [CW-1:0]            w_vec_waddr;
  logic [D_WIDTH-1:0]       w_vec_wdata;
  logic signed [D_WIDTH-1:0]   w_vec_rd;
  logic signed [2*D_WIDTH-1:0] w_prod;
  logic signed [ACC_WIDTH-1:0] w_acc_next;
  logic [D_WIDTH-1:0]       w_res_scaled;

  assign w_size_ok  = (cfg_rows != '0) && (cfg_rows <= SW'(MAX_SIZE)) &&
                      (cfg_cols != '0) && (cfg_cols <= SW'(MAX_SIZE));
  assign w_col_last = (r_col == r_n - SW'(1));
  assign w_row_last = (r_row == r_m - SW'(1));
  assign w_vec_hs   = s_axis_vector_valid & w_vec_ready;
  assign w_mat_hs   = s_axis_matrix_valid & w_mat_ready;

  assign w_vec_rd   = r_vec[r_col[CW-1:0]];
  assign w_prod     = $signed(s_axis_matrix) * w_vec_rd;
  assign w_acc_next = r_acc + {{(ACC_WIDTH-2*D_WIDTH){w_prod[2*D_WIDTH-1]}}, w_prod};

`ifdef MATVEC_SATURATE_EN
  // Bits above the kept window must all match the result sign, otherwise clamp.
  logic [ACC_WIDTH-FRAC_BITS-D_WIDTH:0] w_hi;
  logic                                 w_ovf;
  assign w_hi  = w_acc_next[ACC_WIDTH-1:FRAC_BITS+D_WIDTH-1];
  assign w_ovf = !((&w_hi) || !(|w_hi));
  assign w_res_scaled = !w_ovf ? w_acc_next[FRAC_BITS +: D_WIDTH] :
                        w_hi[ACC_WIDTH-FRAC_BITS-D_WIDTH] ? {1'b1, {(D_WIDTH-1){1'b0}}} :
                                                            {1'b0, {(D_WIDTH-1){1'b1}}};
`else
  assign w_res_scaled = w_acc_next[FRAC_BITS +: D_WIDTH];
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= S_INIT;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_vec_ready = 1'b0;
    w_mat_ready = 1'b0;
    case (r_state)
      S_INIT:  if (r_col == SW'(MAX_SIZE-1)) w_next = S_IDLE;
      S_IDLE: begin
        w_vec_ready = w_size_ok && !r_cfg_err;
        if (s_axis_vector_valid && w_vec_ready)
          w_next = (cfg_cols == SW'(1)) ? S_MAC : S_LOAD;
      end
      S_LOAD: begin
        w_vec_ready = 1'b1;
        if (s_axis_vector_valid && w_col_last) w_next = S_MAC;
      end
      S_MAC: begin
        w_mat_ready = !r_res_valid || m_axis_result_ready;
        if (s_axis_matrix_valid && w_mat_ready && w_col_last && w_row_last) w_next = S_DRAIN;
      end
      S_DRAIN: if (r_res_valid && m_axis_result_ready) w_next = S_IDLE;
      default: w_next = S_INIT;
    endcase
  end

  always_comb begin
    w_vec_we    = 1'b0;
    w_vec_waddr = r_col[CW-1:0];
    w_vec_wdata = s_axis_vector;
    if (r_state == S_INIT) begin
      w_vec_we    = 1'b1;
      w_vec_wdata = '0;
    end else if (w_vec_hs) begin
      w_vec_we = 1'b1;
      if (r_state == S_IDLE) w_vec_waddr = '0;
    end
  end

  // The vector store is cleared by INIT after every reset, so it needs no reset itself.
  always_ff @(posedge aclk) begin
    if (w_vec_we) r_vec[w_vec_waddr] <= w_vec_wdata;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_m <= '0; r_n <= '0; r_col <= '0; r_row <= '0;
      r_acc <= '0; r_res <= '0; r_res_valid <= 1'b0; r_res_last <= 1'b0;
      r_busy <= 1'b0; r_cfg_err <= 1'b0; r_reset_done <= 1'b0;
    end else begin
      if (r_res_valid && m_axis_result_ready) r_res_valid <= 1'b0;
      case (r_state)
        S_INIT: begin
          if (r_col == SW'(MAX_SIZE-1)) begin
            r_col        <= '0;
            r_reset_done <= 1'b1;
          end else begin
            r_col <= r_col + SW'(1);
          end
        end
        S_IDLE: begin
          if (s_axis_vector_valid && !w_size_ok) r_cfg_err <= 1'b1;
          if (w_vec_hs) begin
            r_m    <= cfg_rows;
            r_n    <= cfg_cols;
            r_busy <= 1'b1;
            r_row  <= '0;
            r_acc  <= '0;
            r_col  <= (cfg_cols == SW'(1)) ? '0 : SW'(1);
          end
        end
        S_LOAD: begin
          if (w_vec_hs) r_col <= w_col_last ? '0 : r_col + SW'(1);
        end
        S_MAC: begin
          if (w_mat_hs) begin
            if (w_col_last) begin
              r_res       <= w_res_scaled;
              r_res_valid <= 1'b1;
              r_res_last  <= w_row_last;
              r_acc       <= '0;
              r_col       <= '0;
              r_row       <= r_row + SW'(1);
            end else begin
              r_acc <= w_acc_next;
              r_col <= r_col + SW'(1);
            end
          end
        end
        S_DRAIN: if (r_res_valid && m_axis_result_ready) r_busy <= 1'b0;
        default: ;
      endcase
    end
  end

  assign reset_done          = r_reset_done;
  assign cfg_err             = r_cfg_err;
  assign busy                = r_busy;
  assign s_axis_vector_ready = w_vec_ready;
  assign s_axis_matrix_ready = w_mat_ready;
  assign m_axis_result_valid = r_res_valid;
  assign m_axis_result       = r_res;
  assign m_axis_result_last  = r_res_last;
  assign dbg_state           = r_state;
endmodule
